mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single-port instruction/data memory between an instruction-fetch requester and a data
//   load/store requester. Owns the program counter: fetches sequence from RESET_PC in PC_STEP strides,
//   and the PC can be redirected by a load. Sits between the CPU front end and the mem block; drives
//   mem's address/memIn/read/write. mem read data is combinational; mem writes on posedge clk.
// PARAMETERS
//   DW        32   data/instruction word width
//   AW        32   address width
//   RESET_PC  128  PC value after reset
//   PC_STEP   4    PC increment per completed fetch
// PORTS
//   clk        in   1   clock; all state updates on posedge
//   reset      in   1   synchronous, active-high reset
//   f_req      in   1   fetch request; held until f_ack
//   f_ack      out  1   one-cycle pulse: f_inst/f_pc valid
//   f_inst     out  DW  fetched instruction word (registered)
//   f_pc       out  AW  address of the word in f_inst (registered)
//   pc_load    in   1   redirect PC to pc_in this cycle
//   pc_in      in   AW  redirect target
//   d_req      in   1   data request; held until d_ack
//   d_we       in   1   1=store, 0=load; sampled with d_req
//   d_addr     in   AW  data byte address
//   d_wdata    in   DW  store data
//   d_ack      out  1   one-cycle pulse: access done, d_rdata valid for loads
//   d_rdata    out  DW  load data (registered)
//   mem_addr   out  AW  to mem address
//   mem_wdata  out  DW  to mem memIn
//   mem_read   out  1   to mem read
//   mem_write  out  1   to mem write
//   mem_rdata  in   DW  from mem memOut
//   err        out  1   only with ALIGN_CHECK_EN: misaligned-access pulse, coincident with ack
// BEHAVIOUR
//   - Reset: state IDLE, pc=RESET_PC, last_grant=DATA; all outputs 0 (f_pc=0). Reset anywhere
//     aborts the in-flight access; no ack, mem_read/mem_write low from the next cycle.
//   - FSM: IDLE -> ACC_F | ACC_D -> IDLE. IDLE samples f_req/d_req; winner's address/data/we are
//     registered onto mem_* at the IDLE->ACC edge. ACC_x lasts exactly one cycle: mem_read=1 (load or
//     fetch) or mem_write=1 (store). At the ACC->IDLE edge mem_rdata is captured into f_inst or
//     d_rdata, the matching ack is set for one cycle, and mem_read/mem_write clear. mem_addr/mem_wdata
//     hold their last value outside ACC.
//   - Latency: req seen in IDLE at cycle N -> ack high in N+2. Throughput: one access per 2 cycles.
//   - A req still high during its ack cycle counts as a new request (back-to-back accesses).
//   - Arbitration: only one requester -> it wins. Both -> grant the one not in last_grant
//     (round-robin); last_grant updates on every grant. First tie after reset goes to fetch.
//   - Fetch address is pc. On fetch completion pc <= pc+PC_STEP, wrapping mod 2^AW; f_pc <= fetched
//     address. pc_load sets pc <= pc_in in any state; pc_load on the completion cycle wins over
//     increment. An in-flight fetch still completes with its old address and pulses f_ack.
//   - Stores: d_rdata unchanged; d_ack still pulses. f_ack and d_ack never high together.
// CONFIGURATION
//   ALIGN_CHECK_EN defined: err port exists. A granted access with addr[1:0]!=0 (fetch or data)
//     still takes the ACC cycle but mem_read/mem_write stay 0; the ack pulses with data 0 and err=1
//     for that one cycle. The PC still advances after a misaligned fetch.
//   ALIGN_CHECK_EN undefined: no err port; addresses pass to mem unmodified, no checking.
// TESTING
//   1. Reset, f_req held high -> mem_addr 128,132,136,... with mem_read pulses; f_ack every 2nd cycle; f_pc 128,132,...
//   2. f_req and d_req (load 0x200) both held -> grants alternate F,D,F,D; first grant is fetch; no starvation.
//   3. Store d_addr=0x204 d_wdata=0xDEADBEEF -> mem_write high exactly 1 cycle at 0x204; then load 0x204 -> d_rdata=0xDEADBEEF.
//   4. pc_load=1 pc_in=0x100 on fetch-completion cycle at pc=128 -> next fetch address 0x100, not 132.
//   5. reset asserted during ACC_D of a store -> mem_write 0 next cycle, no d_ack, next fetch at 128.
//   6. ALIGN_CHECK_EN, load d_addr=0x203 -> mem_read stays 0, d_ack=1 with err=1, d_rdata=0; without macro mem_addr=0x203.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of signals around the memory-port arbiter: the fetch requester,
// the data load/store requester, and the single-port memory.
//
// Handshake: a requester raises *_req and holds it, together with its
// address/data/we, until the arbiter returns a one-cycle *_ack. Data
// returned by a load or fetch is valid in the ack cycle. A req still high
// during its ack cycle is taken as the next request.
//
// Optional feature macro: ALIGN_CHECK_EN adds the err signal.
interface mem_port_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          f_req;
  logic          f_ack;
  logic [DW-1:0] f_inst;
  logic [AW-1:0] f_pc;
  logic          pc_load;
  logic [AW-1:0] pc_in;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;
`ifdef ALIGN_CHECK_EN
  logic          err;

  // Arbiter side.
  modport slave (
    input  f_req, pc_load, pc_in, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_ack, f_inst, f_pc, d_ack, d_rdata,
           mem_addr, mem_wdata, mem_read, mem_write, err
  );

  // Requester and memory side.
  modport master (
    output f_req, pc_load, pc_in, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_ack, f_inst, f_pc, d_ack, d_rdata,
           mem_addr, mem_wdata, mem_read, mem_write, err
  );
`else
  // Arbiter side.
  modport slave (
    input  f_req, pc_load, pc_in, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_ack, f_inst, f_pc, d_ack, d_rdata,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  // Requester and memory side.
  modport master (
    output f_req, pc_load, pc_in, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_ack, f_inst, f_pc, d_ack, d_rdata,
           mem_addr, mem_wdata, mem_read, mem_write
  );
`endif
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data
// load/store. Owns the program counter. Every access is IDLE -> ACC -> IDLE:
// the winner's request is registered onto mem_* on entry to ACC and the
// memory read data is captured on the way back to IDLE, where the ack
// pulses. Round-robin on ties, fetch first after reset.
//
// Optional feature macro: ALIGN_CHECK_EN (misaligned accesses are
// suppressed at the memory and flagged on err with the ack).
module mem_port_arbiter #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int unsigned RESET_PC = 128,
  parameter int unsigned PC_STEP = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_F = 2'd1,
    ACC_D = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic          last_data;  // 1: the most recent grant went to data
  logic          cur_we;     // the granted data access is a store
  logic          cur_mis;    // the granted access is misaligned
  logic          grant_f;
  logic          f_mis;
  logic          d_mis;

  assign dbg_state = state;

  // Fetch wins when alone or when data had the previous grant.
  assign grant_f = bus.f_req && (!bus.d_req || last_data);

`ifdef ALIGN_CHECK_EN
  assign f_mis = |pc[1:0];
  assign d_mis = |bus.d_addr[1:0];
`else
  assign f_mis = 1'b0;
  assign d_mis = 1'b0;
`endif

  // Arbiter FSM, PC and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pc            <= AW'(RESET_PC);
      last_data     <= 1'b1;
      cur_we        <= 1'b0;
      cur_mis       <= 1'b0;
      bus.f_ack     <= 1'b0;
      bus.f_inst    <= '0;
      bus.f_pc      <= '0;
      bus.d_ack     <= 1'b0;
      bus.d_rdata   <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
`ifdef ALIGN_CHECK_EN
      bus.err       <= 1'b0;
`endif
    end else begin
      bus.f_ack <= 1'b0;
      bus.d_ack <= 1'b0;
`ifdef ALIGN_CHECK_EN
      bus.err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant_f) begin
            state        <= ACC_F;
            last_data    <= 1'b0;
            cur_mis      <= f_mis;
            bus.mem_addr <= pc;
            bus.mem_read <= !f_mis;
          end else if (bus.d_req) begin
            state         <= ACC_D;
            last_data     <= 1'b1;
            cur_we        <= bus.d_we;
            cur_mis       <= d_mis;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
            bus.mem_read  <= !bus.d_we && !d_mis;
            bus.mem_write <= bus.d_we && !d_mis;
          end
        end
        ACC_F: begin
          state        <= IDLE;
          bus.mem_read <= 1'b0;
          bus.f_ack    <= 1'b1;
          bus.f_inst   <= cur_mis ? '0 : bus.mem_rdata;
          bus.f_pc     <= bus.mem_addr;
          pc           <= pc + AW'(PC_STEP);
`ifdef ALIGN_CHECK_EN
          bus.err      <= cur_mis;
`endif
        end
        ACC_D: begin
          state         <= IDLE;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
          bus.d_ack     <= 1'b1;
          if (!cur_we) begin
            bus.d_rdata <= cur_mis ? '0 : bus.mem_rdata;
          end
`ifdef ALIGN_CHECK_EN
          bus.err       <= cur_mis;
`endif
        end
        default: state <= IDLE;
      endcase
      // A redirect overrides the post-fetch increment.
      if (bus.pc_load) begin
        pc <= bus.pc_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory, a
// scoreboard of expected memory accesses / fetch results / data results,
// and bounded waits on every ack.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       init_mem;
  logic [1:0] dbg_state;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         wr_cnt = 0;

  logic [AW:0]    acc_q[$];  // {is_write, addr}
  logic [63:0]    f_q[$];    // {f_pc, f_inst}
  logic [DW-1:0]  d_q[$];    // d_rdata at each d_ack

  logic [DW-1:0] mem [0:1023];

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  mem_port_arbiter #(
    .DW(DW), .AW(AW), .RESET_PC(128), .PC_STEP(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  // Single-port memory: combinational read, write on posedge.
  assign bus.mem_rdata = mem[bus.mem_addr[11:2]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.mem_read || bus.mem_write) begin
      if (bus.mem_write) wr_cnt++;
      if (acc_q.size() == 0) check("acc_unexpected", 64'(acc_q.size()), 64'd1);
      else check("acc", 64'({bus.mem_write, bus.mem_addr}), 64'(acc_q.pop_front()));
    end
    if (bus.f_ack || bus.d_ack) begin
      check("ack_excl", 64'(bus.f_ack && bus.d_ack), 64'd0);
    end
    if (bus.f_ack) begin
      if (f_q.size() == 0) check("f_unexpected", 64'(f_q.size()), 64'd1);
      else check("fetch", {bus.f_pc, bus.f_inst}, f_q.pop_front());
    end
    if (bus.d_ack) begin
      if (d_q.size() == 0) check("d_unexpected", 64'(d_q.size()), 64'd1);
      else check("data", 64'(bus.d_rdata), 64'(d_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for an ack: which 0=fetch, 1=data, 2=either. n = cycles waited.
  task automatic wait_ack(input int which, input string tag, output int n);
    logic got;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      n++;
      got = (which == 0) ? bus.f_ack : (which == 1) ? bus.d_ack : (bus.f_ack || bus.d_ack);
    end
    if (!got) check({tag, "_timeout"}, 64'(got), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push_fetch(input int addr);
    acc_q.push_back({1'b0, 32'(addr)});
    f_q.push_back({32'(addr), init_word(addr >> 2)});
  endtask

  int n;
  int wr0;

  initial begin
    reset = 1'b1;
    init_mem = 1'b1;
    bus.f_req = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_in = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    step();
    init_mem = 1'b0;
    step();

    // Reset state.
    check("rst_f_ack", 64'(bus.f_ack), 64'd0);
    check("rst_d_ack", 64'(bus.d_ack), 64'd0);
    check("rst_f_pc", 64'(bus.f_pc), 64'd0);
    check("rst_f_inst", 64'(bus.f_inst), 64'd0);
    check("rst_d_rdata", 64'(bus.d_rdata), 64'd0);
    check("rst_mem_rd", 64'(bus.mem_read), 64'd0);
    check("rst_mem_wr", 64'(bus.mem_write), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;

    // Sequential fetch stream from the reset PC, one ack per 2 cycles.
    for (int k = 0; k < 4; k++) push_fetch(128 + 4 * k);
    bus.f_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(0, "seq", n);
      check("seq_latency", 64'(n), 64'd2);
`ifdef ALIGN_CHECK_EN
      check("seq_err", 64'(bus.err), 64'd0);
`endif
    end
    bus.f_req = 1'b0;
    step();

    // Both requesters held: F,D,F,D,F,D starting with fetch after reset.
    do_reset();
    bus.f_req = 1'b1;
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h200;
    for (int k = 0; k < 3; k++) begin
      push_fetch(128 + 4 * k);
      acc_q.push_back({1'b0, 32'h200});
      d_q.push_back(init_word(32'h200 >> 2));
    end
    for (int k = 0; k < 6; k++) wait_ack(2, "rr", n);
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    step();

    // Store then load back; the store leaves d_rdata alone.
    wr0 = wr_cnt;
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 32'h204;
    bus.d_wdata = 32'hDEAD_BEEF;
    acc_q.push_back({1'b1, 32'h204});
    d_q.push_back(init_word(32'h200 >> 2));
    wait_ack(1, "store", n);
    check("store_rdata_hold", 64'(bus.d_rdata), 64'(init_word(32'h200 >> 2)));
    check("store_wr_cycles", 64'(wr_cnt - wr0), 64'd1);
    bus.d_we = 1'b0;
    acc_q.push_back({1'b0, 32'h204});
    d_q.push_back(32'hDEAD_BEEF);
    wait_ack(1, "load", n);
    bus.d_req = 1'b0;
    check("load_back", 64'(bus.d_rdata), 64'h0000_0000_DEAD_BEEF);
    step();

    // Redirect on the completion cycle of the fetch at 128.
    do_reset();
    push_fetch(128);
    push_fetch(32'h100);
    bus.f_req = 1'b1;
    step();
    bus.pc_load = 1'b1;
    bus.pc_in = 32'h100;
    wait_ack(0, "redir1", n);
    bus.pc_load = 1'b0;
    wait_ack(0, "redir2", n);
    bus.f_req = 1'b0;
    step();

    // Reset during the access cycle of a store.
    do_reset();
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 32'h208;
    bus.d_wdata = 32'h1234_5678;
    acc_q.push_back({1'b1, 32'h208});
    step();
    check("abort_in_acc", 64'(dbg_state), 64'd2);
    reset = 1'b1;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    step();
    check("abort_mem_wr", 64'(bus.mem_write), 64'd0);
    check("abort_d_ack", 64'(bus.d_ack), 64'd0);
    reset = 1'b0;
    push_fetch(128);
    bus.f_req = 1'b1;
    wait_ack(0, "abort_fetch", n);
    bus.f_req = 1'b0;
    step();

    // Misaligned load.
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h203;
`ifdef ALIGN_CHECK_EN
    d_q.push_back('0);
    wait_ack(1, "misalign", n);
    check("misalign_err", 64'(bus.err), 64'd1);
    check("misalign_rdata", 64'(bus.d_rdata), 64'd0);
`else
    acc_q.push_back({1'b0, 32'h203});
    d_q.push_back(init_word(32'h200 >> 2));
    wait_ack(1, "misalign", n);
    check("misalign_addr", 64'(bus.mem_addr), 64'h203);
`endif
    bus.d_req = 1'b0;
    step();
    step();

    check("acc_q_empty", 64'(acc_q.size()), 64'd0);
    check("f_q_empty", 64'(f_q.size()), 64'd0);
    check("d_q_empty", 64'(d_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
